// File: rtl/charger_pkg.sv
// Shared charger constants, session state encoding and small arithmetic helpers.
// The display driver imports the same defaults, so keep them in sync here.
package charger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_TIMING
  } state_e;

  localparam int unsigned DEF_DIV_COUNT = 50_000_000;
  localparam int unsigned DEF_MAX_MONEY = 20;
  localparam int unsigned DEF_UNIT_SEC  = 2;
  localparam int unsigned KEY_MAX_DIGIT = 9;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned bits_for(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic [31:0] sat32(input logic [31:0] v, input logic [31:0] cap);
    return (v > cap) ? cap : v;
  endfunction

endpackage

// File: rtl/charge_session_ctrl_if.sv
// Keypad/command inputs and display/relay outputs of the charge session controller.
interface charge_session_ctrl_if #(
  parameter int unsigned MONEY_W = 5,
  parameter int unsigned TIME_W  = 6
);
  logic               key_valid;
  logic [3:0]         key_value;
  logic               start;
  logic               cancel;
  logic [MONEY_W-1:0] all_money;
  logic [TIME_W-1:0]  remaining_time;
  logic               timing;
  logic               done;
  logic               key_err;

  modport master (
    output key_valid, key_value, start, cancel,
    input  all_money, remaining_time, timing, done, key_err
  );

  modport slave (
    input  key_valid, key_value, start, cancel,
    output all_money, remaining_time, timing, done, key_err
  );
endinterface

// File: rtl/charge_session_ctrl_tick_gen.sv
// Countdown prescaler: one-cycle tick every DIV_COUNT enabled cycles.
// clr has priority and parks the counter at zero.
module tick_gen
  import charger_pkg::*;
#(
  parameter int unsigned DIV_COUNT = DEF_DIV_COUNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     CNT_W    = bits_for(DIV_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && !clr && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/charge_session_ctrl.sv
// Charge session controller: keypad amount entry with saturation, conversion to
// seconds, prescaled countdown, cancel, optional top-up and completion pulse.
module charge_session_ctrl
  import charger_pkg::*;
#(
  parameter int unsigned DIV_COUNT  = DEF_DIV_COUNT,
  parameter int unsigned MAX_MONEY  = DEF_MAX_MONEY,
  parameter int unsigned UNIT_SEC   = DEF_UNIT_SEC,
  parameter int unsigned MAX_DIGITS = 2,
  parameter bit          TOPUP_EN   = 1'b0
) (
  input logic                  clk,
  input logic                  rst_n,
  charge_session_ctrl_if.slave bus
);

  localparam int unsigned MONEY_W = bits_for(MAX_MONEY);
  localparam int unsigned TIME_W  = bits_for(MAX_MONEY * UNIT_SEC);
  localparam int unsigned DIG_W   = bits_for(MAX_DIGITS);
  localparam logic [31:0] MONEY_CAP = 32'(MAX_MONEY);
  localparam logic [31:0] TIME_CAP  = 32'(MAX_MONEY * UNIT_SEC);

  state_e             state_q, state_d;
  logic [MONEY_W-1:0] money_q, money_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [DIG_W-1:0]   digits_q, digits_d;
  logic               timing_q, timing_d;
  logic               done_q, done_d;
  logic               key_err_q, key_err_d;

  logic        tick;
  logic        key_ok;
  logic        key_bad;
  logic        topup_hit;
  logic [31:0] d_ext;
  logic [31:0] money_ext;
  logic [31:0] time_ext;
  logic [31:0] entry_money;
  logic [31:0] topup_money;
  logic [31:0] topup_add;
  logic [31:0] time_next;

  tick_gen #(
    .DIV_COUNT(DIV_COUNT)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == ST_TIMING),
    .clr  (state_q != ST_TIMING),
    .tick (tick)
  );

  assign key_ok    = bus.key_valid && (32'(bus.key_value) <= KEY_MAX_DIGIT);
  assign key_bad   = bus.key_valid && (32'(bus.key_value) >  KEY_MAX_DIGIT);
  assign topup_hit = TOPUP_EN && key_ok;

  // All arithmetic is done 32 bits wide and clamped before narrowing, so nothing wraps.
  assign d_ext       = 32'(bus.key_value);
  assign money_ext   = 32'(money_q);
  assign time_ext    = 32'(time_q);
  assign entry_money = sat32(money_ext * 32'd10 + d_ext, MONEY_CAP);
  assign topup_money = sat32(money_ext + d_ext, MONEY_CAP);
  assign topup_add   = topup_hit ? d_ext * 32'(UNIT_SEC) : '0;
  assign time_next   = sat32(time_ext - 32'(tick) + topup_add, TIME_CAP);

  always_comb begin
    state_d   = state_q;
    money_d   = money_q;
    time_d    = time_q;
    digits_d  = digits_q;
    timing_d  = timing_q;
    done_d    = 1'b0;
    key_err_d = key_bad;

    unique case (state_q)
      ST_IDLE: begin
        if (!bus.cancel && key_ok) begin
          state_d  = ST_ENTRY;
          money_d  = MONEY_W'(sat32(d_ext, MONEY_CAP));
          digits_d = DIG_W'(1);
        end
      end

      ST_ENTRY: begin
        if (bus.cancel) begin
          state_d  = ST_IDLE;
          money_d  = '0;
          time_d   = '0;
          timing_d = 1'b0;
          digits_d = '0;
        end else if (bus.start) begin
          // A start with no money is ignored but still swallows a same-cycle key.
          if (money_q != '0) begin
            state_d  = ST_TIMING;
            timing_d = 1'b1;
            time_d   = TIME_W'(money_ext * 32'(UNIT_SEC));
          end
        end else if (key_ok && (digits_q < DIG_W'(MAX_DIGITS))) begin
          money_d  = MONEY_W'(entry_money);
          digits_d = digits_q + DIG_W'(1);
        end
      end

      ST_TIMING: begin
        if (bus.cancel) begin
          state_d  = ST_IDLE;
          money_d  = '0;
          time_d   = '0;
          timing_d = 1'b0;
          digits_d = '0;
        end else if (time_next == '0) begin
          state_d  = ST_IDLE;
          money_d  = '0;
          time_d   = '0;
          timing_d = 1'b0;
          digits_d = '0;
          done_d   = 1'b1;
        end else begin
          time_d = TIME_W'(time_next);
          if (topup_hit) begin
            money_d = MONEY_W'(topup_money);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      money_q   <= '0;
      time_q    <= '0;
      digits_q  <= '0;
      timing_q  <= 1'b0;
      done_q    <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      money_q   <= money_d;
      time_q    <= time_d;
      digits_q  <= digits_d;
      timing_q  <= timing_d;
      done_q    <= done_d;
      key_err_q <= key_err_d;
    end
  end

  assign bus.all_money      = money_q;
  assign bus.remaining_time = time_q;
  assign bus.timing         = timing_q;
  assign bus.done           = done_q;
  assign bus.key_err        = key_err_q;

endmodule

// File: tb/tb_charge_session_ctrl.sv
// Bench for charge_session_ctrl: two instances (top-up off / on) share one stimulus
// and are compared every cycle against a behavioural session model.
module tb_charge_session_ctrl;
  import charger_pkg::*;

  localparam int unsigned DIV  = 4;
  localparam int unsigned MAXM = 20;
  localparam int unsigned UNIT = 2;
  localparam int unsigned MAXD = 2;
  localparam int unsigned CAP  = MAXM * UNIT;
  localparam int unsigned MW   = bits_for(MAXM);
  localparam int unsigned TW   = bits_for(CAP);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_value = 4'd0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;

  always #5 clk = ~clk;

  charge_session_ctrl_if #(.MONEY_W(MW), .TIME_W(TW)) bus0 ();
  charge_session_ctrl_if #(.MONEY_W(MW), .TIME_W(TW)) bus1 ();

  assign bus0.key_valid = key_valid;
  assign bus0.key_value = key_value;
  assign bus0.start     = start;
  assign bus0.cancel    = cancel;
  assign bus1.key_valid = key_valid;
  assign bus1.key_value = key_value;
  assign bus1.start     = start;
  assign bus1.cancel    = cancel;

  charge_session_ctrl #(
    .DIV_COUNT(DIV), .MAX_MONEY(MAXM), .UNIT_SEC(UNIT), .MAX_DIGITS(MAXD), .TOPUP_EN(1'b0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  charge_session_ctrl #(
    .DIV_COUNT(DIV), .MAX_MONEY(MAXM), .UNIT_SEC(UNIT), .MAX_DIGITS(MAXD), .TOPUP_EN(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Session model: amount, seconds left, whether charging/entering, digits typed,
  // and cycles elapsed since charging began (a tick lands on every DIV-th one).
  int m_money[2], m_rem[2], m_digits[2], m_cyc[2];
  bit m_charging[2], m_entering[2], m_done[2], m_kerr[2];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_clear(input int i);
    m_money[i] = 0; m_rem[i] = 0; m_digits[i] = 0; m_cyc[i] = 0;
    m_charging[i] = 0; m_entering[i] = 0; m_done[i] = 0; m_kerr[i] = 0;
  endtask

  task automatic model_step(input int i, input bit topup);
    int  d;
    bit  legal;
    int  r;
    d      = int'(key_value);
    legal  = key_valid && (d <= 9);
    m_kerr[i] = key_valid && (d > 9);
    m_done[i] = 0;
    if (m_charging[i]) begin
      if (cancel) begin
        m_charging[i] = 0; m_money[i] = 0; m_rem[i] = 0;
      end else begin
        m_cyc[i]++;
        r = m_rem[i] - (((m_cyc[i] % DIV) == 0) ? 1 : 0);
        if (topup && legal) begin
          r = r + d * UNIT;
          m_money[i] = imin(m_money[i] + d, MAXM);
        end
        r = imin(r, CAP);
        if (r == 0) begin
          m_done[i] = 1; m_charging[i] = 0; m_money[i] = 0; m_rem[i] = 0;
        end else begin
          m_rem[i] = r;
        end
      end
    end else if (m_entering[i]) begin
      if (cancel) begin
        m_entering[i] = 0; m_money[i] = 0; m_rem[i] = 0;
      end else if (start) begin
        if (m_money[i] > 0) begin
          m_entering[i] = 0; m_charging[i] = 1;
          m_rem[i] = m_money[i] * UNIT; m_cyc[i] = 0;
        end
      end else if (legal && m_digits[i] < MAXD) begin
        m_money[i] = imin(m_money[i] * 10 + d, MAXM);
        m_digits[i]++;
      end
    end else if (!cancel && legal) begin
      m_entering[i] = 1; m_money[i] = imin(d, MAXM); m_digits[i] = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear(0);
      model_clear(1);
    end else begin
      model_step(0, 1'b0);
      model_step(1, 1'b1);
    end
  end

  task automatic cmp_outputs(input int i, input int money, input int rem,
                             input int tmg, input int dn, input int ke);
    chk($sformatf("dut%0d.all_money", i), money, m_money[i]);
    chk($sformatf("dut%0d.remaining_time", i), rem, m_rem[i]);
    chk($sformatf("dut%0d.timing", i), tmg, int'(m_charging[i]));
    chk($sformatf("dut%0d.done", i), dn, int'(m_done[i]));
    chk($sformatf("dut%0d.key_err", i), ke, int'(m_kerr[i]));
  endtask

  always @(negedge clk) begin
    cmp_outputs(0, int'(bus0.all_money), int'(bus0.remaining_time),
                int'(bus0.timing), int'(bus0.done), int'(bus0.key_err));
    cmp_outputs(1, int'(bus1.all_money), int'(bus1.remaining_time),
                int'(bus1.timing), int'(bus1.done), int'(bus1.key_err));
  end

  // Stimulus helpers are entered just after a falling edge and return one cycle later.
  task automatic press(input int d);
    key_value = 4'(d);
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int done_at;
    int saw_done;

    repeat (2) @(negedge clk);
    chk("reset.money", int'(bus0.all_money), 0);
    chk("reset.rem", int'(bus0.remaining_time), 0);
    chk("reset.timing", int'(bus0.timing), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal session 15 units -> 30 s -> 120 cycles
    press(1);
    press(5);
    chk("s1.money", int'(bus0.all_money), 15);
    chk("s1.model_money", m_money[0], 15);
    do_start();
    chk("s1.rem", int'(bus0.remaining_time), 30);
    chk("s1.timing", int'(bus0.timing), 1);
    done_at = -1;
    for (int n = 1; n <= 200 && done_at < 0; n++) begin
      @(negedge clk);
      if (bus0.done) done_at = n;
    end
    chk("s1.done_latency", done_at, 120);
    chk("s1.end_timing", int'(bus0.timing), 0);
    chk("s1.end_money", int'(bus0.all_money), 0);
    @(negedge clk);
    chk("s1.done_drop", int'(bus0.done), 0);

    // Saturation and digit limit
    press(9);
    press(9);
    chk("s2.money_sat", int'(bus0.all_money), 20);
    press(9);
    chk("s2.third_digit", int'(bus0.all_money), 20);
    do_start();
    chk("s2.rem", int'(bus0.remaining_time), 40);
    do_cancel();
    chk("s2.cancel_rem", int'(bus0.remaining_time), 0);
    chk("s2.cancel_timing", int'(bus0.timing), 0);

    // Start ignored in IDLE and with zero money; key 0 still opens entry
    do_start();
    chk("s3.idle_start", int'(bus0.timing), 0);
    press(0);
    do_start();
    chk("s3.zero_start", int'(bus0.timing), 0);
    press(7);
    press(3);
    chk("s3.digits_after_zero", int'(bus0.all_money), 7);
    do_cancel();

    // Cancel mid-charge
    press(3);
    do_start();
    chk("s4.rem", int'(bus0.remaining_time), 6);
    idle(20);
    chk("s4.rem_after_5", int'(bus0.remaining_time), 1);
    do_cancel();
    chk("s4.cancel_rem", int'(bus0.remaining_time), 0);
    chk("s4.cancel_timing", int'(bus0.timing), 0);
    chk("s4.cancel_money", int'(bus0.all_money), 0);
    saw_done = 0;
    for (int n = 0; n < 10; n++) begin
      if (bus0.done || bus1.done) saw_done = 1;
      @(negedge clk);
    end
    chk("s4.no_done", saw_done, 0);

    // Illegal digit
    press(4);
    press(12);
    chk("s5.key_err", int'(bus0.key_err), 1);
    chk("s5.money_kept", int'(bus0.all_money), 4);
    idle(1);
    chk("s5.key_err_drop", int'(bus0.key_err), 0);
    do_cancel();

    // Top-up: dut1 adds time, dut0 ignores the keys
    press(5);
    do_start();
    chk("s6.rem_start", int'(bus1.remaining_time), 10);
    idle(15);
    chk("s6.rem_before", int'(bus1.remaining_time), 7);
    press(9);
    chk("s6.topup_rem", int'(bus1.remaining_time), 24);
    chk("s6.topup_money", int'(bus1.all_money), 14);
    chk("s6.off_rem", int'(bus0.remaining_time), 6);
    chk("s6.off_money", int'(bus0.all_money), 5);
    press(9);
    chk("s6.cap_rem", int'(bus1.remaining_time), 40);
    chk("s6.cap_money", int'(bus1.all_money), 20);
    chk("s6.model_cap", m_rem[1], 40);
    chk("s6.off_rem2", int'(bus0.remaining_time), 6);

    // Asynchronous reset mid-session
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    chk("s7.rst_timing0", int'(bus0.timing), 0);
    chk("s7.rst_rem0", int'(bus0.remaining_time), 0);
    chk("s7.rst_timing1", int'(bus1.timing), 0);
    chk("s7.rst_rem1", int'(bus1.remaining_time), 0);
    chk("s7.rst_money1", int'(bus1.all_money), 0);
    chk("s7.rst_done1", int'(bus1.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (bus0.done || bus1.done) saw_done = 1;
    end
    chk("s7.no_done", saw_done, 0);

    // Zero top-up on the completion tick still completes
    press(1);
    do_start();
    chk("s8.rem", int'(bus1.remaining_time), 2);
    idle(7);
    chk("s8.rem_last", int'(bus1.remaining_time), 1);
    press(0);
    chk("s8.done1", int'(bus1.done), 1);
    chk("s8.timing1", int'(bus1.timing), 0);
    chk("s8.done0", int'(bus0.done), 1);
    idle(1);
    chk("s8.done_drop", int'(bus1.done), 0);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/charge_session_ctrl.md
# charge_session_ctrl

Parametrised successor to the charger's amount/timing controller. Accepts coin amounts as validated decimal key digits, saturates them at a configurable maximum and converts the amount to charging seconds. It then counts the session down on an internal 1 Hz-equivalent tick. Over the previous generation it adds cancel, optional top-up during charging and a completion pulse. It sits between the keypad decoder and the display/relay drivers.

## Interface
- `DIV_COUNT`, default 50000000: clk cycles per countdown tick (1 s at 50 MHz).
- `MAX_MONEY`, default 20: saturation value of the entered amount.
- `UNIT_SEC`, default 2: charging seconds per money unit.
- `MAX_DIGITS`, default 2: maximum digits accepted per entry; further digits are ignored.
- `TOPUP_EN`, default 0: 1 allows keys during charging to add time.
- `MONEY_W`, derived: $clog2(MAX_MONEY+1).
- `TIME_W`, derived: $clog2(MAX_MONEY*UNIT_SEC+1).
- `clk  in  1`: system clock; the block's single clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `key_valid  in  1`: one-cycle strobe; `key_value` is sampled only while it is high.
- `key_value  in  4`: decimal digit. Values 10–15 are illegal.
- `start  in  1`: level or pulse; sampled each cycle.
- `cancel  in  1`: sampled each cycle; aborts entry or charging.
- `all_money  out  MONEY_W`: current amount.
- `remaining_time  out  TIME_W`: seconds left.
- `timing  out  1`: high while charging.
- `done  out  1`: one-cycle pulse on natural completion.
- `key_err  out  1`: one-cycle pulse on an illegal digit.

## Operation
- Reset (async assert, sync release) drives these values: state IDLE, all_money=0, remaining_time=0, timing=0, done=0, key_err=0, prescaler=0.
- IDLE:
  - A legal key loads all_money=min(d,MAX_MONEY), sets digit count 1 and moves to ENTRY.
  - A key of 0 is legal: ENTRY is entered with money 0.
  - start is ignored.
- ENTRY:
  - A legal key while digit count < MAX_DIGITS: all_money=min(all_money*10+d, MAX_MONEY). Digit count increments.
  - A legal key at MAX_DIGITS is ignored.
  - start with all_money≠0: next cycle timing=1, remaining_time=all_money*UNIT_SEC, prescaler cleared, state TIMING.
  - start with all_money=0 is ignored.
- TIMING:
  - On each tick, remaining_time decrements.
  - The tick taking remaining_time from 1 to 0 ends the session:
    - in that same edge: remaining_time=0, timing=0, done=1 for one cycle, all_money=0, state IDLE;
    - done drops on the following cycle.
  - TOPUP_EN=1, legal key d: remaining_time=min(remaining_time+d*UNIT_SEC, MAX_MONEY*UNIT_SEC) and all_money=min(all_money+d, MAX_MONEY).
  - TOPUP_EN=0: keys are ignored.
- cancel in ENTRY or TIMING: next cycle returns to IDLE with all_money, remaining_time and timing cleared. done is not asserted.
- An illegal digit (>9) in any state pulses key_err the next cycle. It changes nothing else.
- Arithmetic is computed at the full width of the product and sum before clamping. Outputs never wrap.

## Timing
- All outputs are registered. Response latency to key_valid, start and cancel is one clk.
- The prescaler runs only in TIMING. A tick fires every DIV_COUNT cycles.
- The first tick comes DIV_COUNT cycles after the cycle in which timing rises.
- Priority within a cycle: cancel > start > key.
  - In ENTRY, start and a key in the same cycle: the key is discarded.
  - In TIMING, a tick and a top-up in the same cycle: result = min(remaining_time−1+d*UNIT_SEC, cap).
  - A top-up on the completion tick still completes when the result is 0, i.e. d=0. Any nonzero top-up keeps charging.
- Reset mid-session aborts immediately. done does not pulse.

## Structure
- The package `charger_pkg` holds:
  - the state enum (IDLE, ENTRY, TIMING);
  - the width helper function;
  - the default constants for DIV_COUNT, MAX_MONEY and UNIT_SEC. These are shared with the display driver.
- Sub-module `tick_gen` is parameterised on DIV_COUNT. Its inputs are enable and sync clear; its output is a one-cycle tick pulse.
- The FSM, entry datapath and countdown live in `charge_session_ctrl`.

## Test plan
Unless a scenario says otherwise: DIV_COUNT=4, MAX_MONEY=20, UNIT_SEC=2, MAX_DIGITS=2, TOPUP_EN=0.
- Keys 1 then 5, then start → all_money=15, remaining_time=30, timing=1. 30 ticks (120 cycles) later: done pulses once, timing=0, all_money=0.
- Keys 9, 9, 9 → all_money=20 (saturated; third digit ignored). Start → remaining_time=40.
- Start in IDLE, or start after key 0 → no state change, timing stays 0.
- Key 3, start, then cancel after 5 ticks → next cycle IDLE, remaining_time=0, done never asserted.
- Key 12 in ENTRY → key_err pulses, all_money unchanged.
- TOPUP_EN=1:
  - all_money=5 charging at remaining_time=7, key 9 with a simultaneous tick → remaining_time=min(6+18,40)=24, all_money=14;
  - key 9 again → remaining_time capped at 40, all_money capped at 20.
- rst_n low mid-TIMING → all outputs 0 asynchronously; no done pulse.
